// File: rtl/uart_fifo_pkg.sv
// Shared types for the FIFO-backed UART register block.
// Register indices, STATUS field positions and the CTRL layout.
package uart_fifo_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_STATUS = 2'd1,
    REG_CTRL   = 2'd2
  } reg_e;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_RX_VALID = 1;
  localparam int ST_TX_IDLE  = 2;
  localparam int ST_RX_OVF   = 3;
  localparam int ST_TX_OVF   = 4;
  localparam int ST_RX_CNT   = 8;
  localparam int ST_TX_CNT   = 16;
  localparam int CNT_W       = 8;

  typedef struct packed {
    logic loopback;
    logic tx_irq_en;
    logic rx_irq_en;
  } ctrl_t;

endpackage

// File: rtl/uart_rx.sv
// Deserialiser: samples mid-bit after a 2-flop synchroniser.
// A start bit that is high at mid-point is treated as a glitch.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CPB - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_e;

  state_e st;
  state_e st_n;
  logic [1:0] sync;
  logic rxs;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [3:0] nb;
  logic [3:0] nb_n;
  logic [DATA_WIDTH-1:0] sh_n;
  logic vld_n;

  assign rxs = sync[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync    <= '1;
      st      <= S_IDLE;
      cnt     <= '0;
      nb      <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      sync    <= {sync[0], rx_i};
      st      <= st_n;
      cnt     <= cnt_n;
      nb      <= nb_n;
      data_o  <= sh_n;
      valid_o <= vld_n;
    end
  end

  always_comb begin
    st_n  = st;
    cnt_n = cnt + 1'b1;
    nb_n  = nb;
    sh_n  = data_o;
    vld_n = valid_o && !ready_i;
    unique case (st)
      S_IDLE: begin
        cnt_n = '0;
        if (!rxs) st_n = S_START;
      end
      S_START: if (cnt == HALF) begin
        cnt_n = '0;
        nb_n  = '0;
        st_n  = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: if (cnt == FULL) begin
        cnt_n = '0;
        sh_n  = {rxs, data_o[DATA_WIDTH-1:1]};
        nb_n  = nb + 1'b1;
        if (nb == 4'(DATA_WIDTH - 1)) st_n = S_STOP;
      end
      S_STOP: if (cnt == FULL) begin
        cnt_n = '0;
        st_n  = S_IDLE;
        vld_n = vld_n || rxs;
      end
      default: st_n = S_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers.
// A pop on a full FIFO frees room for a same-cycle push.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  import uart_fifo_pkg::*;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic do_push;
  logic do_pop;

  assign empty_o = (wptr == rptr);
  assign full_o  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count_o = wptr - rptr;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr[AW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Serialiser: 1 start, DATA_WIDTH data LSB-first, 1 stop.
// Ready in the last stop-bit cycle so queued characters follow with no gap.
module uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  tx_o
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB + 1);
  localparam int FW  = DATA_WIDTH + 2;

  logic [FW-1:0] sh;
  logic [CW-1:0] cnt;
  logic [3:0]    nb;
  logic busy;
  logic tick;
  logic last;

  assign tick    = busy && (cnt == CW'(CPB - 1));
  assign last    = tick && (nb == 4'(FW - 1));
  assign ready_o = !busy || last;
  assign tx_o    = sh[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh   <= '1;
      cnt  <= '0;
      nb   <= '0;
      busy <= 1'b0;
    end else if (valid_i && ready_o) begin
      sh   <= {1'b1, data_i, 1'b0};
      cnt  <= '0;
      nb   <= '0;
      busy <= 1'b1;
    end else if (tick) begin
      sh   <= {1'b1, sh[FW-1:1]};
      cnt  <= '0;
      nb   <= nb + 1'b1;
      busy <= !last;
    end else if (busy) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_fifo_regs.sv
// Memory-mapped UART with TX/RX FIFOs, sticky overflow flags and irq.
// Define UART_FIFO_LOOPBACK_EN to make CTRL bit2 an internal loopback.
module uart_fifo_regs #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        irq_o,
  input  logic        rx_i,
  output logic        tx_o
);
  import uart_fifo_pkg::*;

  localparam int TXW = $clog2(TX_DEPTH) + 1;
  localparam int RXW = $clog2(RX_DEPTH) + 1;

  logic wr, rd, w1c;
  logic tx_push, tx_pop, tx_full, tx_empty, tx_ready, tx_idle;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic tx_ser, rx_line, tx_ovf, rx_ovf;
  logic [DATA_WIDTH-1:0] tx_dout, rx_din, rx_dout;
  logic [TXW-1:0] tx_cnt;
  logic [RXW-1:0] rx_cnt;
  logic [31:0] rd_d;
  ctrl_t ctrl;
  reg_e sel;
  logic unused_ok;

  assign sel     = reg_e'(addr_i[3:2]);
  assign wr      = req_i && we_i;
  assign rd      = req_i && !we_i;
  assign w1c     = wr && (sel == REG_STATUS);
  assign tx_push = wr && (sel == REG_DATA);
  assign rx_pop  = rd && (sel == REG_DATA);
  assign tx_pop  = !tx_empty && tx_ready;
  assign tx_idle = tx_empty && tx_ready;
  assign unused_ok = &{1'b0, wdata_i, addr_i};

`ifdef UART_FIFO_LOOPBACK_EN
  assign tx_o    = ctrl.loopback ? 1'b1 : tx_ser;
  assign rx_line = ctrl.loopback ? tx_ser : rx_i;
`else
  assign tx_o    = tx_ser;
  assign rx_line = rx_i;
`endif

  uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i, .rst_ni,
    .push_i(tx_push), .pop_i(tx_pop),
    .data_i(wdata_i[DATA_WIDTH-1:0]), .data_o(tx_dout),
    .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_cnt)
  );

  uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i, .rst_ni,
    .push_i(rx_push), .pop_i(rx_pop),
    .data_i(rx_din), .data_o(rx_dout),
    .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_cnt)
  );

  uart_tx #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_WIDTH(DATA_WIDTH)
  ) u_tx (
    .clk_i, .rst_ni,
    .valid_i(!tx_empty), .data_i(tx_dout),
    .ready_o(tx_ready), .tx_o(tx_ser)
  );

  uart_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_WIDTH(DATA_WIDTH)
  ) u_rx (
    .clk_i, .rst_ni,
    .rx_i(rx_line), .ready_i(1'b1),
    .valid_o(rx_push), .data_o(rx_din)
  );

  always_comb begin
    rd_d = '0;
    unique case (sel)
      REG_DATA: rd_d = rx_empty ? '1 : 32'(rx_dout);
      REG_STATUS: begin
        rd_d[ST_TX_FULL]  = tx_full;
        rd_d[ST_RX_VALID] = !rx_empty;
        rd_d[ST_TX_IDLE]  = tx_idle;
        rd_d[ST_RX_OVF]   = rx_ovf;
        rd_d[ST_TX_OVF]   = tx_ovf;
        rd_d[ST_RX_CNT +: CNT_W] = CNT_W'(rx_cnt);
        rd_d[ST_TX_CNT +: CNT_W] = CNT_W'(tx_cnt);
      end
      REG_CTRL: rd_d = 32'(ctrl);
      default: rd_d = '0;
    endcase
  end

  // Overflow set beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      irq_o    <= 1'b0;
      ctrl     <= '0;
      tx_ovf   <= 1'b0;
      rx_ovf   <= 1'b0;
    end else begin
      rvalid_o <= req_i;
      rdata_o  <= rd ? rd_d : '0;
      irq_o    <= (ctrl.rx_irq_en && !rx_empty) ||
                  (ctrl.tx_irq_en && tx_idle);
      tx_ovf   <= (tx_push && tx_full && !tx_pop) ||
                  (tx_ovf && !(w1c && wdata_i[ST_TX_OVF]));
      rx_ovf   <= (rx_push && rx_full && !rx_pop) ||
                  (rx_ovf && !(w1c && wdata_i[ST_RX_OVF]));
      if (wr && (sel == REG_CTRL)) begin
        ctrl.rx_irq_en <= wdata_i[0];
        ctrl.tx_irq_en <= wdata_i[1];
`ifdef UART_FIFO_LOOPBACK_EN
        ctrl.loopback  <= wdata_i[2];
`endif
      end
    end
  end

endmodule
